pipe_hazard_unit: RTL and testbench

//  Hazard controller for the 5-stage pipelined MIPS core (IF/ID/EX/MEM/WB).

---
 rtl/pipe_hazard_unit.sv | 143 ++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// Hazard controller for the 5-stage MIPS pipeline: shadow scoreboard, stall/flush control and EX forwarding.
// Build option: define HZ_FWD_EN for forwarding with load-use-only stalls; otherwise dependents stall until writeback.
module pipe_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int BR_RESOLVE = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regw,
  input  logic              id_memr,
  input  logic              br_taken,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              exmem_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

`ifdef HZ_FWD_EN
  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dst;
    logic              regw;
    logic              memr;
  } exEnt_t;
`else
  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic              regw;
  } exEnt_t;
  logic unusedIdMemr;
  assign unusedIdMemr = id_memr;
`endif

  // Past EX only the producer fields matter, so later stages drop the source fields.
  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic              regw;
  } prodEnt_t;

  function automatic logic isProd(input logic vld, input logic regw,
                                  input logic [REG_AW-1:0] dst, input logic [REG_AW-1:0] r);
    return vld & regw & (dst == r) & (r != '0);
  endfunction

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic     brTk, stall, stallEff, issue, rsHit, rtHit;
  exEnt_t   idEnt, entry_p0;
  prodEnt_t exProd, entry_p1, entry_p2;
  logic     vld_p0, vld_p1, vld_p2;

`ifdef HZ_FWD_EN
  prodEnt_t entry_p3;
  logic     vld_p3;

  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] r,
                                        input logic v1, input prodEnt_t e1,
                                        input logic v2, input prodEnt_t e2,
                                        input logic v3, input prodEnt_t e3);
    if (isProd(v1, e1.regw, e1.dst, r)) return 2'b01;
    if (isProd(v2, e2.regw, e2.dst, r)) return 2'b10;
    if (isProd(v3, e3.regw, e3.dst, r)) return 2'b11;
    return 2'b00;
  endfunction

  assign idEnt = '{rs: id_rs, rt: id_rt, dst: id_dst, regw: id_regw, memr: id_memr};
  assign rsHit = id_use_rs & entry_p0.memr & isProd(vld_p0, entry_p0.regw, entry_p0.dst, id_rs);
  assign rtHit = id_use_rt & entry_p0.memr & isProd(vld_p0, entry_p0.regw, entry_p0.dst, id_rt);
  assign fwd_a = vld_p0 ? fwdSel(entry_p0.rs, vld_p1, entry_p1, vld_p2, entry_p2, vld_p3, entry_p3) : 2'b00;
  assign fwd_b = vld_p0 ? fwdSel(entry_p0.rt, vld_p1, entry_p1, vld_p2, entry_p2, vld_p3, entry_p3) : 2'b00;
`else
  assign idEnt = '{dst: id_dst, regw: id_regw};
  assign rsHit = id_use_rs & (isProd(vld_p0, entry_p0.regw, entry_p0.dst, id_rs) |
                              isProd(vld_p1, entry_p1.regw, entry_p1.dst, id_rs) |
                              isProd(vld_p2, entry_p2.regw, entry_p2.dst, id_rs));
  assign rtHit = id_use_rt & (isProd(vld_p0, entry_p0.regw, entry_p0.dst, id_rt) |
                              isProd(vld_p1, entry_p1.regw, entry_p1.dst, id_rt) |
                              isProd(vld_p2, entry_p2.regw, entry_p2.dst, id_rt));
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  // Branch is masked while in reset so every output shows its reset value immediately.
  assign brTk     = br_taken & reset;
  assign stall    = id_valid & (rsHit | rtHit);
  assign stallEff = stall & ~brTk;
  assign issue    = id_valid & ~stall & ~brTk;

  assign pc_we       = ~stallEff;
  assign ifid_we     = ~stallEff;
  assign ifid_flush  = brTk;
  assign idex_bubble = brTk | stall;
  assign exmem_flush = (BR_RESOLVE == 3) ? brTk : 1'b0;
  assign exProd      = '{dst: entry_p0.dst, regw: entry_p0.regw};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
`ifdef HZ_FWD_EN
      vld_p3    <= 1'b0;
`endif
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      vld_p0 <= issue;
      vld_p1 <= vld_p0 & ~exmem_flush;
      vld_p2 <= vld_p1;
`ifdef HZ_FWD_EN
      vld_p3 <= vld_p2;
`endif
      if (stallEff) stall_cnt <= satInc(stall_cnt);
      if (brTk)     flush_cnt <= satInc(flush_cnt);
    end
  end

  // ID -> EX -> MEM -> WB -> WB+1 shadow fields; bubbles load zeros
  always_ff @(posedge clock) begin
    entry_p0 <= issue ? idEnt : '0;
    entry_p1 <= exmem_flush ? '0 : exProd;
    entry_p2 <= entry_p1;
`ifdef HZ_FWD_EN
    entry_p3 <= entry_p2;
`endif
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed scoreboard bench for pipe_hazard_unit; a second instance (CNT_W=2, BR_RESOLVE=2) covers saturation.
module tb_pipe_hazard_unit;
  localparam int NRM = 0, STL = 1, BRK = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0, id_regw = 1'b0, id_memr = 1'b0, br_taken = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;

  logic pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic satPcWe, satIfidWe, satIfidFlush, satIdexBubble, satExmemFlush;
  logic [1:0] unusedSatFwdA, unusedSatFwdB, satStallCnt, satFlushCnt;

  always #5 clock = ~clock;

  pipe_hazard_unit #(.REG_AW(5), .BR_RESOLVE(3), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_regw(id_regw),
    .id_memr(id_memr), .br_taken(br_taken), .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipe_hazard_unit #(.REG_AW(5), .BR_RESOLVE(2), .CNT_W(2)) dutSat (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_regw(id_regw),
    .id_memr(id_memr), .br_taken(br_taken), .pc_we(satPcWe), .ifid_we(satIfidWe),
    .ifid_flush(satIfidFlush), .idex_bubble(satIdexBubble), .exmem_flush(satExmemFlush),
    .fwd_a(unusedSatFwdA), .fwd_b(unusedSatFwdB), .stall_cnt(satStallCnt), .flush_cnt(satFlushCnt));

  typedef struct packed {
    logic pcWe, ifidWe, ifidFlush, idexBubble, exmemFlush;
    logic [1:0] fwdA, fwdB;
    logic [15:0] sc, fc;
    logic [1:0] scS, fcS;
  } exp_t;

  exp_t sbQ[$];
  int nAssert = 0;
  int nFail = 0;
  logic [15:0] scM = '0, fcM = '0;
  logic [1:0] scSM = '0, fcSM = '0;

  function automatic logic [1:0] fwE(input logic [1:0] x);
`ifdef HZ_FWD_EN
    return x;
`else
    return 2'b00 & x;
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic idv, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic [4:0] dst,
                      input logic rw, input logic mr, input logic br, input int kind,
                      input logic [1:0] faE, input logic [1:0] fbE);
    exp_t e, o;
    @(negedge clock);
    id_valid = idv; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dst = dst; id_regw = rw; id_memr = mr; br_taken = br;
    e.pcWe = (kind != STL); e.ifidWe = (kind != STL); e.ifidFlush = (kind == BRK);
    e.idexBubble = (kind != NRM); e.exmemFlush = (kind == BRK);
    e.fwdA = faE; e.fwdB = fbE; e.sc = scM; e.fc = fcM; e.scS = scSM; e.fcS = fcSM;
    sbQ.push_back(e);
    if (kind == STL) begin
      if (scM != 16'hFFFF) scM = scM + 16'd1;
      if (scSM != 2'd3) scSM = scSM + 2'd1;
    end
    if (kind == BRK) begin
      if (fcM != 16'hFFFF) fcM = fcM + 16'd1;
      if (fcSM != 2'd3) fcSM = fcSM + 2'd1;
    end
    #1;
    o = sbQ.pop_front();
    chk("pc_we", pc_we, o.pcWe);
    chk("ifid_we", ifid_we, o.ifidWe);
    chk("ifid_flush", ifid_flush, o.ifidFlush);
    chk("idex_bubble", idex_bubble, o.idexBubble);
    chk("exmem_flush", exmem_flush, o.exmemFlush);
    chk("fwd_a", fwd_a, o.fwdA);
    chk("fwd_b", fwd_b, o.fwdB);
    chk("stall_cnt", stall_cnt, o.sc);
    chk("flush_cnt", flush_cnt, o.fc);
    chk("sat_pc_we", satPcWe, o.pcWe);
    chk("sat_ifid_flush", satIfidFlush, o.ifidFlush);
    chk("sat_exmem_flush", satExmemFlush, 1'b0);
    chk("sat_stall_cnt", satStallCnt, o.scS);
    chk("sat_flush_cnt", satFlushCnt, o.fcS);
  endtask

  task automatic idle(input logic [1:0] fa, input logic [1:0] fb);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, fa, fb);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) idle(0, 0);
  endtask

  task automatic loadUse();
    step(1, 0, 0, 0, 0, 5, 1, 1, 0, NRM, 0, 0);
`ifdef HZ_FWD_EN
    step(1, 0, 5, 0, 1, 12, 1, 0, 0, STL, 0, 0);
    step(1, 0, 5, 0, 1, 12, 1, 0, 0, NRM, 0, 0);
    idle(0, 2'b10);
`else
    for (int i = 0; i < 3; i++) step(1, 0, 5, 0, 1, 12, 1, 0, 0, STL, 0, 0);
    step(1, 0, 5, 0, 1, 12, 1, 0, 0, NRM, 0, 0);
    idle(0, 0);
`endif
    drain(3);
  endtask

  initial begin
    #1 reset = 1'b0;
    #11;
    chk("rst_pc_we", pc_we, 1'b1);
    chk("rst_ifid_we", ifid_we, 1'b1);
    chk("rst_idex_bubble", idex_bubble, 1'b0);
    chk("rst_fwd_a", fwd_a, 2'b00);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    #11 reset = 1'b1;
    drain(2);

`ifdef HZ_FWD_EN
    step(1, 1, 2, 1, 1, 3, 1, 0, 0, NRM, 0, 0);          // add r3
    step(1, 3, 2, 1, 1, 8, 1, 0, 0, NRM, 0, 0);          // sub r8 <- r3
    step(1, 3, 0, 1, 0, 9, 1, 0, 0, NRM, 2'b01, 0);      // or r9 <- r3
    step(1, 3, 3, 1, 1, 11, 1, 0, 0, NRM, 2'b10, 0);     // and r11 <- r3,r3
    idle(2'b11, 2'b11);
    drain(4);
    step(1, 0, 0, 0, 0, 5, 1, 1, 0, NRM, 0, 0);          // lw r5
    step(1, 1, 5, 1, 1, 10, 1, 0, 0, STL, 0, 0);
    step(1, 1, 5, 1, 1, 10, 1, 0, 0, NRM, 0, 0);
    idle(0, 2'b10);
    drain(4);
    step(1, 1, 2, 1, 1, 3, 1, 0, 0, NRM, 0, 0);          // two writers of r3
    step(1, 1, 2, 1, 1, 3, 1, 0, 0, NRM, 0, 0);
    step(1, 3, 0, 1, 0, 0, 0, 0, 0, NRM, 0, 0);
    idle(2'b01, 0);
    drain(4);
`else
    step(1, 1, 2, 1, 1, 4, 1, 0, 0, NRM, 0, 0);          // add r4
    for (int i = 0; i < 3; i++) step(1, 4, 0, 1, 0, 6, 1, 0, 0, STL, 0, 0);
    step(1, 4, 0, 1, 0, 6, 1, 0, 0, NRM, 0, 0);
    drain(4);
    step(1, 1, 2, 1, 1, 4, 1, 0, 0, NRM, 0, 0);          // add r4, reader two slots later
    drain(2);
    step(1, 0, 4, 0, 1, 0, 0, 0, 0, STL, 0, 0);
    step(1, 0, 4, 0, 1, 0, 0, 0, 0, NRM, 0, 0);
    drain(4);
`endif

    step(1, 0, 0, 0, 0, 0, 1, 1, 0, NRM, 0, 0);          // lw r0 then reader of r0
    step(1, 0, 0, 1, 1, 7, 1, 0, 0, NRM, 0, 0);
    drain(4);
    step(1, 0, 0, 0, 0, 5, 1, 1, 0, NRM, 0, 0);          // lw r5, rs=r5 field but not read
    step(1, 5, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0);
    idle(fwE(2'b01), 0);
    drain(4);

    step(1, 0, 0, 0, 0, 5, 1, 1, 0, NRM, 0, 0);          // branch on top of load-use
    step(1, 0, 5, 0, 1, 10, 1, 0, 1, BRK, 0, 0);
    idle(0, 0);
    drain(3);

    for (int i = 0; i < 4; i++) loadUse();
    chk("sat_stall_cnt_held", satStallCnt, 2'd3);

    step(1, 0, 0, 0, 0, 5, 1, 1, 0, NRM, 0, 0);
    step(1, 0, 5, 0, 1, 12, 1, 0, 0, STL, 0, 0);
    #1 reset = 1'b0;
    #1;
    chk("midrst_pc_we", pc_we, 1'b1);
    chk("midrst_ifid_we", ifid_we, 1'b1);
    chk("midrst_idex_bubble", idex_bubble, 1'b0);
    chk("midrst_stall_cnt", stall_cnt, 16'd0);
    chk("midrst_flush_cnt", flush_cnt, 16'd0);
    chk("midrst_sat_stall_cnt", satStallCnt, 2'd0);
    scM = '0; fcM = '0; scSM = '0; fcSM = '0;
    @(posedge clock);
    #1;
    id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_regw = 0; id_memr = 0; br_taken = 0;
    @(negedge clock);
    reset = 1'b1;
    drain(3);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
